switch_input_ctrl: RTL and testbench

- Parametrised, bus-attached input peripheral for WIDTH physical switches/buttons.
- Each input passes through a synchroniser, then a per-bit debounce counter, then a per-bit edge detector. Edges set sticky pending flags, which drive a maskable interrupt.
- Sits on the 4-way handshaking data bus; software reads debounced state and pending edges, configures edge masks, and clears pending bits.

---
 rtl/switch_input_ctrl.sv | 164 ++++++++++++++++
 tb/tb_switch_input_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : switch_input_ctrl
// Summary  : Synchronised, debounced switch inputs with edge-pending IRQ on a
//            4-way handshake register bus.
// Revision : 1.0
// ============================================================================
module switch_input_ctrl #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Read,
    input  logic             Write,
    input  logic [1:0]       Address,
    input  logic [31:0]      DataIn,
    output logic [31:0]      DataOut,
    output logic             Ack,
    input  logic [WIDTH-1:0] Switch_in,
    output logic [WIDTH-1:0] Switch_out,
    output logic             Interrupt
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [CNT_W-1:0] r_cnt  [WIDTH];
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] w_irq_en;
    logic [31:0]      w_irq_rd;

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr_start;
    logic             w_rd_start;
    logic [31:0]      w_rdata;
    logic             w_unused_data;

    assign w_unused_data = ^DataIn;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= Switch_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // A bit is accepted only when it has disagreed with the stable level for
    // DEBOUNCE_CYCLES consecutive samples; any agreement restarts the count.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_accept[i] = (w_s[i] != r_stable[i]) && (r_cnt[i] == c_cnt_max);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_stable <= r_stable ^ w_accept;
            for (int i = 0; i < WIDTH; i++) begin
                if (w_s[i] == r_stable[i] || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign Switch_out = r_stable;

    // Edges are flagged in the same cycle the stable level flips.
    assign w_rise = w_accept & w_s;
    assign w_fall = w_accept & ~w_s;
    assign w_set  = (w_rise & r_rise_en) | (w_fall & r_fall_en);

    assign w_wr_start = Write & ~Ack;
    assign w_rd_start = Read & ~Ack;
    assign w_clr      = (w_wr_start && Address == 2'd1) ? DataIn[WIDTH-1:0] : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (w_wr_start && Address == 2'd2) begin
                r_rise_en <= DataIn[WIDTH-1:0];
            end
            if (w_wr_start && Address == 2'd3) begin
                r_fall_en <= DataIn[WIDTH-1:0];
            end
        end
    end

    // irq_en shares register 3 with fall_en and only fits for narrow builds.
    generate
        if (WIDTH <= 16) begin : g_irq_reg
            logic [WIDTH-1:0] r_irq_en;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_irq_en <= '0;
                end else if (w_wr_start && Address == 2'd3) begin
                    r_irq_en <= DataIn[WIDTH+15:16];
                end
            end
            assign w_irq_en = r_irq_en;
            assign w_irq_rd = 32'(r_irq_en) << 16;
        end else begin : g_irq_fixed
            assign w_irq_en = '1;
            assign w_irq_rd = '0;
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        case (Address)
            2'd0:    w_rdata = 32'(r_stable);
            2'd1:    w_rdata = 32'(r_pending);
            2'd2:    w_rdata = 32'(r_rise_en);
            default: w_rdata = 32'(r_fall_en) | w_irq_rd;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Ack       <= 1'b0;
            DataOut   <= '0;
            Interrupt <= 1'b0;
        end else begin
            Ack       <= Read | Write;
            Interrupt <= |(r_pending & w_irq_en);
            if (w_rd_start) begin
                DataOut <= w_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_switch_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_input_ctrl
// Summary  : Directed plus randomised bench with a window-based debounce model.
// Revision : 1.0
// ============================================================================
module tb_switch_input_ctrl;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int DC = 4;
    localparam int HD = SS + DC;

    logic          clock   = 1'b0;
    logic          reset   = 1'b0;
    logic          Read    = 1'b0;
    logic          Write   = 1'b0;
    logic [1:0]    Address = '0;
    logic [31:0]   DataIn  = '0;
    logic [31:0]   DataOut;
    logic          Ack;
    logic [W-1:0]  Switch_in = '0;
    logic [W-1:0]  Switch_out;
    logic          Interrupt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    switch_input_ctrl #(
        .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .CNT_W(3)
    ) dut (
        .clock(clock), .reset(reset), .Read(Read), .Write(Write),
        .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .Ack(Ack),
        .Switch_in(Switch_in), .Switch_out(Switch_out), .Interrupt(Interrupt)
    );

    // Reference model: a level is accepted once the last DC synchronised
    // samples all differ from the current stable level.
    logic [W-1:0] m_hist [HD];
    logic [W-1:0] m_stable = '0, m_pend = '0, m_rise = '0, m_fall = '0, m_irqen = '0;
    logic         m_ack = 1'b0, m_irq = 1'b0;
    logic [31:0]  m_dout = '0;
    logic [W-1:0] m_nst, m_set, m_clr;
    logic [31:0]  m_rd;
    logic         m_sw, m_sr, m_flip;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < HD; j++) m_hist[j] = '0;
            m_stable = '0; m_pend = '0; m_rise = '0; m_fall = '0; m_irqen = '0;
            m_ack = 1'b0; m_irq = 1'b0; m_dout = '0;
        end else begin
            m_sw = Write && !m_ack;
            m_sr = Read && !m_ack;
            case (Address)
                2'd0:    m_rd = {24'd0, m_stable};
                2'd1:    m_rd = {24'd0, m_pend};
                2'd2:    m_rd = {24'd0, m_rise};
                default: m_rd = {8'd0, m_irqen, 8'd0, m_fall};
            endcase
            for (int j = HD - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = Switch_in;
            m_nst = m_stable;
            for (int i = 0; i < W; i++) begin
                m_flip = 1'b1;
                for (int j = SS; j < HD; j++) begin
                    if (m_hist[j][i] == m_stable[i]) m_flip = 1'b0;
                end
                if (m_flip) m_nst[i] = ~m_stable[i];
            end
            m_set = ((m_nst & ~m_stable) & m_rise) | ((~m_nst & m_stable) & m_fall);
            m_clr = (m_sw && Address == 2'd1) ? DataIn[W-1:0] : '0;
            m_irq = |(m_pend & m_irqen);
            m_pend = (m_pend & ~m_clr) | m_set;
            if (m_sw && Address == 2'd2) m_rise = DataIn[W-1:0];
            if (m_sw && Address == 2'd3) begin
                m_fall  = DataIn[W-1:0];
                m_irqen = DataIn[23:16];
            end
            if (m_sr) m_dout = m_rd;
            m_ack = Read || Write;
            m_stable = m_nst;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        chk("switch_out", {24'd0, Switch_out}, {24'd0, m_stable});
        chk("interrupt", {31'd0, Interrupt}, {31'd0, m_irq});
        chk("ack", {31'd0, Ack}, {31'd0, m_ack});
        chk("dataout", DataOut, m_dout);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic bus_op(input logic rd, input logic wr, input logic [1:0] a,
                          input logic [31:0] d, output logic [31:0] q);
        int t;
        Address = a; DataIn = d; Read = rd; Write = wr;
        t = 0;
        do begin step(); t++; end while (Ack !== 1'b1 && t < 10);
        chk("bus_ack_rise", {31'd0, Ack}, 32'd1);
        q = DataOut;
        Read = 1'b0; Write = 1'b0;
        t = 0;
        do begin step(); t++; end while (Ack !== 1'b0 && t < 10);
        chk("bus_ack_fall", {31'd0, Ack}, 32'd0);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] q;
        bus_op(1'b0, 1'b1, a, d, q);
    endtask

    task automatic bus_read_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] q;
        bus_op(1'b1, 1'b0, a, 32'd0, q);
        chk(tag, q, exp);
    endtask

    initial begin
        logic [31:0] q;
        int r;
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // 1: mid-run reset during a read, then release latency
        Switch_in = 8'hFF;
        steps(10);
        Address = 2'd0; Read = 1'b1;
        step();
        chk("pre_reset_dout", DataOut, 32'hFF);
        #1 reset = 1'b1;
        #1;
        chk("rst_switch_out", {24'd0, Switch_out}, 32'd0);
        chk("rst_ack", {31'd0, Ack}, 32'd0);
        chk("rst_irq", {31'd0, Interrupt}, 32'd0);
        chk("rst_dout", DataOut, 32'd0);
        Read = 1'b0;
        step();
        reset = 1'b0;
        steps(5);
        chk("latency_before", {24'd0, Switch_out}, 32'd0);
        step();
        chk("latency_at", {24'd0, Switch_out}, 32'hFF);
        bus_read_chk(2'd1, 32'd0, "pend_masked");

        // 2: glitch rejection then accepted level
        Switch_in = 8'h00; steps(8);
        Switch_in = 8'h01; steps(3);
        Switch_in = 8'h00; steps(8);
        chk("glitch", {24'd0, Switch_out}, 32'd0);
        Switch_in = 8'h01; steps(5);
        chk("bit0_before", {24'd0, Switch_out}, 32'd0);
        step();
        chk("bit0_at", {24'd0, Switch_out}, 32'h01);
        Switch_in = 8'h00; steps(8);

        // 3: rise pending, interrupt, W1C
        bus_write(2'd2, 32'h01);
        bus_write(2'd3, 32'h0001_0000);
        Switch_in = 8'h01; steps(6);
        chk("irq_pre", {31'd0, Interrupt}, 32'd0);
        step();
        chk("irq_post", {31'd0, Interrupt}, 32'd1);
        bus_read_chk(2'd1, 32'h1, "pend_rd");
        bus_write(2'd1, 32'h1);
        chk("irq_clr", {31'd0, Interrupt}, 32'd0);
        bus_read_chk(2'd1, 32'h0, "pend_clr");

        // 4: set beats a simultaneous clear
        bus_write(2'd2, 32'h08);
        Switch_in = 8'h09; steps(5);
        Address = 2'd1; DataIn = 32'h08; Write = 1'b1;
        step();
        chk("sw_ack", {31'd0, Ack}, 32'd1);
        Write = 1'b0;
        step();
        bus_read_chk(2'd1, 32'h08, "set_wins");

        // 5: held write clears once, later edge survives
        bus_write(2'd2, 32'h01);
        bus_write(2'd1, 32'hFF);
        Switch_in = 8'h08; steps(8);
        Switch_in = 8'h09; steps(8);
        bus_read_chk(2'd1, 32'h01, "pend_pre_hold");
        Switch_in = 8'h08; steps(8);
        Switch_in = 8'h09; steps(2);
        Address = 2'd1; DataIn = 32'h1; Write = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_ack", {31'd0, Ack}, 32'd1);
        end
        Write = 1'b0;
        step();
        chk("hold_ack_drop", {31'd0, Ack}, 32'd0);
        bus_read_chk(2'd1, 32'h01, "edge_kept");

        // 6: fall-only mask
        bus_write(2'd2, 32'h00);
        bus_write(2'd3, 32'h0001_0080);
        bus_write(2'd1, 32'hFF);
        Switch_in = 8'h89; steps(8);
        bus_read_chk(2'd1, 32'h00, "no_rise_pend");
        Switch_in = 8'h09;
        bus_read_chk(2'd0, 32'h89, "stable_rd");
        steps(8);
        bus_read_chk(2'd1, 32'h80, "fall_pend");
        bus_read_chk(2'd3, 32'h0001_0080, "cfg_rd");

        // randomised traffic against the model
        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                Switch_in = W'($urandom);
                steps($urandom_range(1, 9));
            end else if (r < 8) begin
                bus_op(1'b1, 1'b0, 2'($urandom), 32'd0, q);
            end else begin
                bus_op(($urandom_range(0, 3) == 0), 1'b1, 2'($urandom), $urandom, q);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
